// File: rtl/adaptation_logic_s00_axi_regs.sv
// AXI4-Lite slave register file for the S00_AXI port of the Adaptation Logic IP.
// Four 32-bit R/W registers at byte offsets 0x0/0x4/0x8/0xC. The register
// contents and a one-cycle per-register write strobe go to the datapath.
// One outstanding transaction per direction. Accesses with any address bit
// above bit 3 set complete with SLVERR and have no side effects.
module adaptation_logic_s00_axi_regs #(
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] C_REG_RESET        = 32'h0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [127:0]                  regs_o,
    output logic [3:0]                    reg_wr_pulse_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        ready_en_reg;
    logic        aw_full_reg;
    logic [1:0]  aw_idx_reg;
    logic        aw_oor_reg;
    logic        w_full_reg;
    logic [31:0] w_data_reg;
    logic [3:0]  w_strb_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic [3:0]  pulse_reg;
    logic [127:0] regs_flat;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic aw_oor;
    logic ar_oor;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Out-of-range detection only exists when the address is wider than the map.
    generate
        if (C_S_AXI_ADDR_WIDTH > 4) begin : g_oor
            assign aw_oor = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
            assign ar_oor = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
        end else begin : g_no_oor
            assign aw_oor = 1'b0;
            assign ar_oor = 1'b0;
        end
    endgenerate

    assign S_AXI_AWREADY = ready_en_reg & ~aw_full_reg & ~bvalid_reg;
    assign S_AXI_WREADY  = ready_en_reg & ~w_full_reg & ~bvalid_reg;
    assign S_AXI_ARREADY = ready_en_reg & ~rvalid_reg;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_full_reg & w_full_reg & ~bvalid_reg;

    // READY outputs stay low until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) ready_en_reg <= 1'b0;
        else          ready_en_reg <= 1'b1;
    end

    // AW and W slots fill independently and drain together on commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full_reg <= 1'b0;
            aw_idx_reg  <= 2'd0;
            aw_oor_reg  <= 1'b0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= 32'd0;
            w_strb_reg  <= 4'd0;
        end else begin
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
            end
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_idx_reg  <= S_AXI_AWADDR[3:2];
                aw_oor_reg  <= aw_oor;
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= S_AXI_WDATA;
                w_strb_reg <= S_AXI_WSTRB;
            end
        end
    end

    // Per-register storage with byte-lane write enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [31:0] value_reg;
            // Merge the strobed byte lanes of a committed in-range write.
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    value_reg <= C_REG_RESET;
                end else if (commit && !aw_oor_reg && aw_idx_reg == 2'(gi)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_reg[b]) value_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
                    end
                end
            end
            assign regs_flat[32*gi +: 32] = value_reg;
        end
    endgenerate

    // Write response and one-cycle write strobe, both launched by the commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
            pulse_reg  <= 4'd0;
        end else begin
            pulse_reg <= 4'd0;
            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= aw_oor_reg ? RESP_SLVERR : RESP_OKAY;
                if (!aw_oor_reg) pulse_reg <= 4'b0001 << aw_idx_reg;
            end else if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Read data is captured at the AR handshake from pre-commit contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= 32'd0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= ar_oor ? 32'd0 : regs_flat[{S_AXI_ARADDR[3:2], 5'd0} +: 32];
            rresp_reg  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign S_AXI_BVALID   = bvalid_reg;
    assign S_AXI_BRESP    = bresp_reg;
    assign S_AXI_RVALID   = rvalid_reg;
    assign S_AXI_RDATA    = rdata_reg;
    assign S_AXI_RRESP    = rresp_reg;
    assign regs_o         = regs_flat;
    assign reg_wr_pulse_o = pulse_reg;

endmodule

// File: tb/tb_adaptation_logic_s00_axi_regs.sv
// Bench for adaptation_logic_s00_axi_regs: directed AXI4-Lite transactions,
// a transaction-level reference model checked every cycle, and literal
// expectations on read data, responses and strobe counts.
module tb_adaptation_logic_s00_axi_regs;

    localparam int          AW      = 6;
    localparam logic [31:0] RST_VAL = 32'h0000_00A5;

    logic          ACLK;
    logic          ARESETN;
    logic [AW-1:0] S_AXI_AWADDR;
    logic [2:0]    S_AXI_AWPROT;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [AW-1:0] S_AXI_ARADDR;
    logic [2:0]    S_AXI_ARPROT;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [127:0]  regs_o;
    logic [3:0]    reg_wr_pulse_o;

    int tests;
    int fails;
    int pulse_cnt [4];

    adaptation_logic_s00_axi_regs #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_REG_RESET(RST_VAL)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .regs_o(regs_o), .reg_wr_pulse_o(reg_wr_pulse_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out, expected handshake at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [4];
    logic [31:0] m_pre  [4];
    logic [5:0]  m_aw_q [$];
    logic [35:0] m_w_q  [$];
    logic        m_ready_en, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic [3:0]  m_pulse, m_nx_pulse;
    logic        m_aw_rdy, m_w_rdy, m_ar_rdy;
    logic [5:0]  m_a;
    logic [35:0] m_wd;
    int          m_idx;

    function automatic logic [127:0] m_flat();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    // Compare against the model on every falling edge, then advance it to
    // the state the next rising edge must produce.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) m_regs[i] = RST_VAL;
            m_aw_q.delete();
            m_w_q.delete();
            m_ready_en = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0; m_pulse = 0;
            chk("rst_regs", regs_o, m_flat());
            chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
            chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
            chk("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'd0);
            chk("rst_pulse", reg_wr_pulse_o, 4'd0);
        end else begin
            m_aw_rdy = m_ready_en && m_aw_q.size() == 0 && !m_bvalid;
            m_w_rdy  = m_ready_en && m_w_q.size() == 0 && !m_bvalid;
            m_ar_rdy = m_ready_en && !m_rvalid;
            chk("awready", S_AXI_AWREADY, m_aw_rdy);
            chk("wready", S_AXI_WREADY, m_w_rdy);
            chk("arready", S_AXI_ARREADY, m_ar_rdy);
            chk("bvalid", S_AXI_BVALID, m_bvalid);
            chk("rvalid", S_AXI_RVALID, m_rvalid);
            if (m_bvalid) chk("bresp", S_AXI_BRESP, m_bresp);
            if (m_rvalid) chk("rdata_rresp", {S_AXI_RRESP, S_AXI_RDATA}, {m_rresp, m_rdata});
            chk("regs_o", regs_o, m_flat());
            chk("wr_pulse", reg_wr_pulse_o, m_pulse);

            m_pre = m_regs;
            m_nx_pulse = 0;
            if (m_aw_q.size() > 0 && m_w_q.size() > 0 && !m_bvalid) begin
                m_a  = m_aw_q.pop_front();
                m_wd = m_w_q.pop_front();
                if (m_a >= 16) begin
                    m_bresp = 2'b10;
                end else begin
                    m_idx = (int'(m_a) / 4) % 4;
                    for (int b = 0; b < 4; b++)
                        if (m_wd[32+b]) m_regs[m_idx][8*b +: 8] = m_wd[8*b +: 8];
                    m_nx_pulse[m_idx] = 1'b1;
                    m_bresp = 2'b00;
                end
                m_bvalid = 1;
            end else if (m_bvalid && S_AXI_BREADY) begin
                m_bvalid = 0;
            end
            if (S_AXI_AWVALID && m_aw_rdy) m_aw_q.push_back(S_AXI_AWADDR);
            if (S_AXI_WVALID && m_w_rdy) m_w_q.push_back({S_AXI_WSTRB, S_AXI_WDATA});
            if (S_AXI_ARVALID && m_ar_rdy) begin
                if (S_AXI_ARADDR >= 16) begin
                    m_rdata = 0;
                    m_rresp = 2'b10;
                end else begin
                    m_rdata = m_pre[(int'(S_AXI_ARADDR) / 4) % 4];
                    m_rresp = 2'b00;
                end
                m_rvalid = 1;
            end else if (m_rvalid && S_AXI_RREADY) begin
                m_rvalid = 0;
            end
            m_pulse = m_nx_pulse;
            m_ready_en = 1;
        end
    end

    // Count write strobes per register over the whole run.
    always @(negedge ACLK) begin
        if (ARESETN)
            for (int i = 0; i < 4; i++) if (reg_wr_pulse_o[i]) pulse_cnt[i]++;
    end

    // ---------------- drivers ----------------
    // w_lead > 0: W presented w_lead cycles before AW; < 0: AW first.
    // bhold < 0: leave the response pending and return once BVALID is seen.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int bhold,
                             output logic [1:0] resp);
        int  aw_start, w_start, cyc;
        bit  aw_done, w_done, aw_hs, w_hs, b_hs;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; cyc = 0; resp = 2'bxx;
        while (!(aw_done && w_done)) begin
            if (cyc == aw_start) begin S_AXI_AWADDR = addr; S_AXI_AWVALID = 1; end
            if (cyc == w_start) begin S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1; end
            @(negedge ACLK);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) begin S_AXI_AWVALID = 0; aw_done = 1; end
            if (w_hs)  begin S_AXI_WVALID = 0; w_done = 1; end
            cyc++;
            if (cyc > 50) begin
                timeout_fail("aw_w_handshake");
                S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
                return;
            end
        end
        cyc = 0; b_hs = 0;
        while (!b_hs) begin
            S_AXI_BREADY = (bhold >= 0 && cyc >= bhold);
            @(negedge ACLK);
            if (bhold < 0 && S_AXI_BVALID) begin
                resp = S_AXI_BRESP;
                return;
            end
            b_hs = S_AXI_BVALID && S_AXI_BREADY;
            if (b_hs) resp = S_AXI_BRESP;
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 50) begin
                timeout_fail("b_handshake");
                b_hs = 1;
            end
        end
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int rhold,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit ar_hs, r_hs;
        cyc = 0; ar_hs = 0; data = 'x; resp = 'x;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
        while (!ar_hs) begin
            @(negedge ACLK);
            ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 50) begin timeout_fail("ar_handshake"); S_AXI_ARVALID = 0; return; end
        end
        S_AXI_ARVALID = 0;
        cyc = 0; r_hs = 0;
        while (!r_hs) begin
            S_AXI_RREADY = (cyc >= rhold);
            @(negedge ACLK);
            r_hs = S_AXI_RVALID && S_AXI_RREADY;
            if (r_hs) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 50) begin timeout_fail("r_handshake"); r_hs = 1; end
        end
        S_AXI_RREADY = 0;
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] exp_vals [4];

    initial begin
        tests = 0; fails = 0;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        ARESETN = 0;
        S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("init_regs_lit", regs_o, {4{RST_VAL}});
        ARESETN = 1;
        repeat (2) @(posedge ACLK);
        #1;

        // Basic write/readback of all four registers.
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, resp);
            $display("[TB] write addr=%0h data=%0h bresp=%0d", 4 * i, i + 1, resp);
            chk("basic_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(4 * i), 0, rd, resp);
            $display("[TB] read  addr=%0h data=%0h rresp=%0d", 4 * i, rd, resp);
            chk("basic_rdata", {resp, rd}, {2'b00, 32'(i + 1)});
            chk("basic_pulse_cnt", 32'(pulse_cnt[i]), 32'd1);
        end

        // Byte strobes.
        axi_write(6'h04, 32'hAABB_CCDD, 4'hF, 0, 0, resp);
        axi_write(6'h04, 32'h1122_3344, 4'h5, 0, 0, resp);
        axi_read(6'h04, 0, rd, resp);
        $display("[TB] strobe read addr=4 data=%0h rresp=%0d", rd, resp);
        chk("strobe_rdata", {resp, rd}, {2'b00, 32'hAA22_CC44});

        // Handshake ordering: W first, then AW first.
        axi_write(6'h08, 32'h1234_5678, 4'hF, 3, 0, resp);
        $display("[TB] w-first write addr=8 bresp=%0d", resp);
        chk("wfirst_bresp", resp, 2'b00);
        axi_write(6'h08, 32'h9ABC_DEF0, 4'hF, -3, 0, resp);
        $display("[TB] aw-first write addr=8 bresp=%0d", resp);
        chk("awfirst_bresp", resp, 2'b00);
        axi_read(6'h08, 0, rd, resp);
        $display("[TB] read addr=8 data=%0h", rd);
        chk("order_rdata", rd, 32'h9ABC_DEF0);
        chk("order_pulse_cnt", 32'(pulse_cnt[2]), 32'd3);

        // Backpressure on B and R.
        axi_write(6'h0C, 32'h0BAD_F00D, 4'hF, 0, 6, resp);
        $display("[TB] bp write addr=c bresp=%0d", resp);
        chk("bp_bresp", resp, 2'b00);
        axi_read(6'h0C, 6, rd, resp);
        $display("[TB] bp read addr=c data=%0h rresp=%0d", rd, resp);
        chk("bp_rdata", {resp, rd}, {2'b00, 32'h0BAD_F00D});

        // Zero-strobe write: OKAY plus a pulse, contents unchanged.
        axi_write(6'h00, 32'hFFFF_FFFF, 4'h0, 0, 0, resp);
        axi_read(6'h00, 0, rd, resp);
        $display("[TB] zero-strobe read addr=0 data=%0h", rd);
        chk("zstrb_rdata", {resp, rd}, {2'b00, 32'h0000_0001});
        chk("zstrb_pulse_cnt", 32'(pulse_cnt[0]), 32'd2);

        // Out of range.
        axi_write(6'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
        $display("[TB] oor write addr=10 bresp=%0d", resp);
        chk("oor_bresp", resp, 2'b10);
        axi_read(6'h10, 0, rd, resp);
        $display("[TB] oor read addr=10 data=%0h rresp=%0d", rd, resp);
        chk("oor_rdata", {resp, rd}, {2'b10, 32'h0});
        exp_vals[0] = 32'h0000_0001; exp_vals[1] = 32'hAA22_CC44;
        exp_vals[2] = 32'h9ABC_DEF0; exp_vals[3] = 32'h0BAD_F00D;
        chk("oor_regs_lit", regs_o, {exp_vals[3], exp_vals[2], exp_vals[1], exp_vals[0]});
        chk("oor_pulse_total", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd10);

        // Reset while a write response is pending.
        axi_write(6'h00, 32'h0000_0055, 4'hF, 0, -1, resp);
        $display("[TB] pending write addr=0 data=55 bresp=%0d", resp);
        chk("pend_reg0", regs_o[31:0], 32'h0000_0055);
        @(posedge ACLK); #1;
        ARESETN = 0;
        #1;
        chk("rst_bvalid_drop", S_AXI_BVALID, 1'b0);
        chk("rst_reg0", regs_o[31:0], RST_VAL);
        @(posedge ACLK); #1;
        ARESETN = 1;
        @(negedge ACLK);
        chk("rel_ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("rel_ready_high", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        $display("[TB] reset mid-operation done, reg0=%0h", regs_o[31:0]);

        repeat (2) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adaptation_logic_s00_axi_regs.md
# adaptation_logic_s00_axi_regs

AXI4-Lite slave register file for the S00_AXI port of the Adaptation Logic IP, directly downstream of the AXI master VIP in the block-design bench. It decodes four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It presents their contents, plus a one-cycle per-register write strobe, to the adaptation datapath. Each direction allows one outstanding transaction.

## Interface
Parameters:
- C_S_AXI_ADDR_WIDTH, 4: byte-address width; must be ≥4.
- C_REG_RESET, 32'h0: reset value of all four registers.

Ports:
- ACLK  in  1  the block's single clock.
- ARESETN  in  1  reset; asynchronous and active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_o  out  128  register contents; reg n occupies bits [32n+31:32n].
- reg_wr_pulse_o  out  4  bit n is high for one cycle when reg n is written.

## Operation
- Decode: index = ADDR[3:2]. ADDR[1:0] is ignored.
  - If any ADDR bit above bit 3 is nonzero, the access is out of range.
- Write path: the AW slot and the W slot latch independently.
  - The AW slot captures on the AWVALID&AWREADY edge; the W slot captures on the WVALID&WREADY edge.
  - Handshakes may occur in either order or in the same cycle.
  - AWREADY = ready_en & ~aw_full & ~BVALID.
  - WREADY = ready_en & ~w_full & ~BVALID.
- Commit: on the first edge where both slots are full and BVALID is 0:
  - In range: update each byte lane of reg[index] whose WSTRB bit is 1; other lanes hold. Pulse reg_wr_pulse_o[index] for the following cycle. BRESP = 2'b00.
  - Out of range: no register or pulse change. BRESP = 2'b10 (SLVERR).
  - Clear both slots and set BVALID.
- BVALID holds until the BVALID&BREADY edge, then clears.
- Write with WSTRB = 0: in range, gives OKAY and pulses reg_wr_pulse_o, with data unchanged.
- Read path: ARREADY = ready_en & ~RVALID.
  - On the ARVALID&ARREADY edge, register RDATA = reg[index] and RRESP = 2'b00.
  - Out of range: RDATA = 0 and RRESP = 2'b10.
  - Set RVALID. RVALID and RDATA hold until the RVALID&RREADY edge.
- Read/write collision: a read handshake on the same edge as a write commit returns the pre-write value. The read and write paths are otherwise fully independent.
- ready_en: a flop cleared by reset and set on the first ACLK edge after ARESETN deasserts.

## Timing
- Reset (ARESETN low, asynchronous) forces:
  - All registers to C_REG_RESET; regs_o = {4{C_REG_RESET}}.
  - Slots cleared; ready_en = 0.
  - AWREADY = WREADY = ARREADY = 0.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0; reg_wr_pulse_o = 0.
- Reset mid-transaction discards latched AW/W and any pending B/R response. No register updates.
- READY outputs first rise one cycle after ARESETN deasserts.
- Write latency: AW and W handshake at edge N → commit at edge N+1.
  - BVALID, the updated regs_o and reg_wr_pulse_o are all visible after edge N+1.
  - Next AW/W acceptance is possible in the cycle after the B handshake.
- Read latency: AR handshake at edge N → RVALID after edge N.
  - Back-to-back reads with RREADY held high: one read every 2 cycles.
- regs_o changes only on commit edges.

## Test plan
- Match the existing S00_AXI bench:
  - Stimulus: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB = 0xF, then read the four addresses back.
  - Required: reads return 0x1..0x4; all BRESP and RRESP = OKAY; each reg_wr_pulse_o bit pulses once.
- Byte strobes:
  - Stimulus: write 0xAABBCCDD to 0x4 with WSTRB = 0xF, then 0x11223344 with WSTRB = 0x5.
  - Required: read of 0x4 returns 0xAA22CC44.
- Handshake ordering:
  - Stimulus: W valid 3 cycles before AW at 0x8; then a separate case with AW before W.
  - Required: the first-arriving slot's READY drops after its handshake; a single commit occurs; BVALID follows the later handshake by one cycle.
- Backpressure:
  - Stimulus: hold BREADY low 5 cycles after a write; hold RREADY low 5 cycles after a read of 0xC.
  - Required: BVALID, RVALID and RDATA are stable throughout; AWREADY, WREADY and ARREADY stay low until the respective handshake.
- Out of range (C_S_AXI_ADDR_WIDTH = 6):
  - Stimulus: write 0xDEADBEEF to 0x10, then read 0x10.
  - Required: BRESP = RRESP = SLVERR; RDATA = 0; regs_o unchanged; no pulse.
- Reset mid-operation:
  - Stimulus: assert ARESETN low while BVALID is pending after a write of 0x55 to 0x0.
  - Required: BVALID drops immediately; reg0 = C_REG_RESET; READY outputs reassert one cycle after release.
